// File: rtl/mem_access_unit.sv
// MEM-stage data-memory responder: turns EX/MEM load/store requests into a single
// req/ack bus transaction, stalls the pipeline until it finishes, and aligns load data.
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_mem_i,
  input  logic        MemWrite_mem_i,
  input  logic [2:0]  BEOp_mem_i,
  input  logic [31:0] ALUOut_mem_i,
  input  logic [31:0] rt_mem_i,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [1:0]       off_q;
  logic             load_pend;
  logic             flushed;

  logic             is_store;
  logic             access;
  logic             misaligned;
  logic             start;
  logic             timeout_hit;
  logic [1:0]       size;
  logic [3:0]       be_calc;
  logic [31:0]      wdata_calc;

  function automatic logic [1:0] size_of(input logic [2:0] op);
    case (op)
      3'b001, 3'b010: size_of = SZ_HALF;
      3'b011, 3'b100: size_of = SZ_BYTE;
      default:        size_of = SZ_WORD;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      SZ_BYTE: store_lanes = {4{d[7:0]}};
      SZ_HALF: store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // Bring the addressed lane down to bit 0, then extend according to BEOp.
  function automatic logic [31:0] load_align(input logic [31:0] w, input logic [2:0] op,
                                             input logic [1:0] off);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (op)
      3'b001:  load_align = {{16{s[15]}}, s[15:0]};
      3'b010:  load_align = {16'h0000, s[15:0]};
      3'b011:  load_align = {{24{s[7]}}, s[7:0]};
      3'b100:  load_align = {24'h000000, s[7:0]};
      default: load_align = s;
    endcase
  endfunction

  assign is_store    = MemWrite_mem_i;
  assign access      = (MemRead_mem_i | MemWrite_mem_i) & ~flush_i;
  assign size        = size_of(BEOp_mem_i);
  assign misaligned  = ((size == SZ_WORD) && (ALUOut_mem_i[1:0] != 2'b00)) ||
                       ((size == SZ_HALF) && ALUOut_mem_i[0]);
  assign start       = (state == IDLE) && access && !misaligned;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    be_calc = 4'b1111;
    case (size)
      SZ_HALF: be_calc = 4'b0011 << ALUOut_mem_i[1:0];
      SZ_BYTE: be_calc = 4'b0001 << ALUOut_mem_i[1:0];
      default: be_calc = 4'b1111;
    endcase
  end

  assign wdata_calc = store_lanes(rt_mem_i, size);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (bus_ack_i || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is held so that nothing
  // leaks out of an IDLE state that still sees a live request on its inputs.
  always_comb begin
    stall_o = 1'b0;
    adel_o  = 1'b0;
    ades_o  = 1'b0;
    if (rst) begin
      stall_o = start || (state == REQ);
      if ((state == IDLE) && access && misaligned) begin
        adel_o = ~is_store;
        ades_o = is_store;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_be_o     <= '0;
      bus_wdata_o  <= '0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      op_q         <= '0;
      off_q        <= '0;
      load_pend    <= 1'b0;
      flushed      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {ALUOut_mem_i[31:2], 2'b00};
            bus_be_o    <= be_calc;
            bus_wdata_o <= wdata_calc;
            op_q        <= BEOp_mem_i;
            off_q       <= ALUOut_mem_i[1:0];
            load_pend   <= ~is_store;
            flushed     <= 1'b0;
            cnt         <= '0;
          end
        end
        REQ: begin
          if (flush_i) flushed <= 1'b1;
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus_ack_i) begin
            bus_req_o    <= 1'b0;
            cnt          <= '0;
            if (load_pend) load_data_o <= load_align(bus_rdata_i, op_q, off_q);
            load_valid_o <= load_pend & ~(flushed | flush_i);
          end else if (timeout_hit) begin
            bus_req_o    <= 1'b0;
            cnt          <= '0;
            load_data_o  <= '0;
            bus_err_o    <= ~(flushed | flush_i);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          load_valid_o <= 1'b0;
          bus_err_o    <= 1'b0;
        end
        default: begin
          load_valid_o <= 1'b0;
          bus_err_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single transactions plus
// hand-written flush, reset, timeout and stray-ack sequences.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_mem_i, MemWrite_mem_i, flush_i, bus_ack_i;
  logic [2:0]  BEOp_mem_i;
  logic [31:0] ALUOut_mem_i, rt_mem_i, bus_rdata_i;
  logic        bus_req_o, bus_we_o, stall_o, load_valid_o, adel_o, ades_o, bus_err_o;
  logic [31:0] bus_addr_o, bus_wdata_o, load_data_o;
  logic [3:0]  bus_be_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .MemRead_mem_i(MemRead_mem_i), .MemWrite_mem_i(MemWrite_mem_i),
    .BEOp_mem_i(BEOp_mem_i), .ALUOut_mem_i(ALUOut_mem_i), .rt_mem_i(rt_mem_i),
    .flush_i(flush_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
    .adel_o(adel_o), .ades_o(ades_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [2:0]  op;
    logic [31:0] addr, rt, rdata;
    int          ack_at;
    logic        eadel, eades;
    int          estalls, ereqs;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic        ewe;
    logic [31:0] ewdata;
    logic        evalid, eerr;
    logic        chk_load;
    logic [31:0] eload;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // One transaction from its IDLE cycle up to and including its DONE cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] rdata, input int ack_at, input int flush_at,
                         output int stalls, output int reqs, output logic adel,
                         output logic ades, output logic [31:0] f_addr,
                         output logic [3:0] f_be, output logic f_we,
                         output logic [31:0] f_wdata, output logic valid,
                         output logic err, output logic [31:0] ld, output bit done);
    stalls = 0; reqs = 0; done = 0; adel = 0; ades = 0;
    f_addr = '0; f_be = '0; f_we = 0; f_wdata = '0; valid = 0; err = 0; ld = '0;
    @(posedge clk); #1;
    MemRead_mem_i = rd; MemWrite_mem_i = wr; BEOp_mem_i = op;
    ALUOut_mem_i = addr; rt_mem_i = rt;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin adel = adel_o; ades = ades_o; end
      if (bus_req_o) begin
        reqs++;
        if (reqs == 1) begin
          f_addr = bus_addr_o; f_be = bus_be_o; f_we = bus_we_o; f_wdata = bus_wdata_o;
        end
        bus_ack_i = (reqs == ack_at);
        bus_rdata_i = rdata;
        if (reqs == flush_at) flush_i = 1'b1;
      end else begin
        bus_ack_i = 1'b0;
      end
      if (stall_o) stalls++;
      else begin
        done = 1; valid = load_valid_o; err = bus_err_o; ld = load_data_o;
      end
    end
    @(posedge clk); #1;
    MemRead_mem_i = 0; MemWrite_mem_i = 0; BEOp_mem_i = '0; ALUOut_mem_i = '0;
    rt_mem_i = '0; flush_i = 0; bus_ack_i = 0;
  endtask

  initial begin
    int st, rq; logic a, s, we, v, e; logic [31:0] fa, fw, ld; logic [3:0] fb; bit dn;

    //           name   rd wr op      addr          rt            rdata         ack adel ades stl rq eaddr         ebe      we ewdata        val err chk eload
    vecs[0]  = '{"lw",    1, 0, 3'b000, 32'h0000_0104, 32'h0,        32'hDEADBEEF, 2, 0, 0, 3, 2, 32'h0000_0104, 4'b1111, 0, 32'h0,        1, 0, 1, 32'hDEADBEEF};
    vecs[1]  = '{"lb",    1, 0, 3'b011, 32'h0000_0103, 32'h0,        32'h80112233, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b1000, 0, 32'h0,        1, 0, 1, 32'hFFFFFF80};
    vecs[2]  = '{"lbu",   1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80112233, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b1000, 0, 32'h0,        1, 0, 1, 32'h00000080};
    vecs[3]  = '{"sh",    0, 1, 3'b001, 32'h0000_0202, 32'h0000ABCD, 32'h0,        1, 0, 0, 2, 1, 32'h0000_0200, 4'b1100, 1, 32'hABCDABCD, 0, 0, 1, 32'h00000080};
    vecs[4]  = '{"lw_mis",1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,         4'b0000, 0, 32'h0,        0, 0, 0, 32'h0};
    vecs[5]  = '{"sh_mis",0, 1, 3'b001, 32'h0000_0201, 32'h0000ABCD, 32'h0,        1, 0, 1, 0, 0, 32'h0,         4'b0000, 0, 32'h0,        0, 0, 0, 32'h0};
    vecs[6]  = '{"lw_to", 1, 0, 3'b000, 32'h0000_0010, 32'h0,        32'h12345678, 0, 0, 0, 17, 16, 32'h0000_0010, 4'b1111, 0, 32'h0,       0, 1, 1, 32'h0};
    vecs[7]  = '{"lh",    1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80010000, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b1100, 0, 32'h0,        1, 0, 1, 32'hFFFF8001};
    vecs[8]  = '{"lhu",   1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'h1234F00F, 1, 0, 0, 2, 1, 32'h0000_0100, 4'b0011, 0, 32'h0,        1, 0, 1, 32'h0000F00F};
    vecs[9]  = '{"sb",    0, 1, 3'b011, 32'h0000_0101, 32'h1234565A, 32'h0,        1, 0, 0, 2, 1, 32'h0000_0100, 4'b0010, 1, 32'h5A5A5A5A, 0, 0, 0, 32'h0};
    vecs[10] = '{"sw",    0, 1, 3'b000, 32'h0000_0300, 32'h12345678, 32'h0,        3, 0, 0, 4, 3, 32'h0000_0300, 4'b1111, 1, 32'h12345678, 0, 0, 0, 32'h0};
    vecs[11] = '{"op111", 1, 0, 3'b111, 32'h0000_0008, 32'h0,        32'hCAFEF00D, 1, 0, 0, 2, 1, 32'h0000_0008, 4'b1111, 0, 32'h0,        1, 0, 1, 32'hCAFEF00D};
    vecs[12] = '{"rd_wr", 1, 1, 3'b000, 32'h0000_0400, 32'h11223344, 32'h0,        1, 0, 0, 2, 1, 32'h0000_0400, 4'b1111, 1, 32'h11223344, 0, 0, 1, 32'hCAFEF00D};
    vecs[13] = '{"ack16", 1, 0, 3'b000, 32'h0000_0020, 32'h0,        32'h0BADF00D, 16, 0, 0, 17, 16, 32'h0000_0020, 4'b1111, 0, 32'h0,     1, 0, 1, 32'h0BADF00D};
    vecs[14] = '{"lhu_mis",1,0, 3'b010, 32'h0000_0103, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0,         4'b0000, 0, 32'h0,        0, 0, 0, 32'h0};
    vecs[15] = '{"sw_mis",0, 1, 3'b000, 32'h0000_0302, 32'h0,        32'h0,        1, 0, 1, 0, 0, 32'h0,         4'b0000, 0, 32'h0,        0, 0, 0, 32'h0};

    rst = 0; MemRead_mem_i = 0; MemWrite_mem_i = 0; BEOp_mem_i = '0; ALUOut_mem_i = '0;
    rt_mem_i = '0; flush_i = 0; bus_ack_i = 0; bus_rdata_i = '0;
    @(negedge clk);
    chk("rst_ctrl", {25'd0, bus_req_o, bus_we_o, stall_o, load_valid_o, adel_o, ades_o, bus_err_o}, 32'h0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_wdata", bus_wdata_o, 32'h0);
    chk("rst_be", {28'd0, bus_be_o}, 32'h0);
    chk("rst_load", load_data_o, 32'h0);
    @(posedge clk); #1 rst = 1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].rdata,
              vecs[i].ack_at, 0, st, rq, a, s, fa, fb, we, fw, v, e, ld, dn);
      chk({vecs[i].name, "_done"}, {31'd0, dn}, 32'd1);
      chk({vecs[i].name, "_adel"}, {31'd0, a}, {31'd0, vecs[i].eadel});
      chk({vecs[i].name, "_ades"}, {31'd0, s}, {31'd0, vecs[i].eades});
      chk({vecs[i].name, "_stalls"}, st, vecs[i].estalls);
      chk({vecs[i].name, "_reqs"}, rq, vecs[i].ereqs);
      if (vecs[i].ereqs > 0) begin
        chk({vecs[i].name, "_addr"}, fa, vecs[i].eaddr);
        chk({vecs[i].name, "_be"}, {28'd0, fb}, {28'd0, vecs[i].ebe});
        chk({vecs[i].name, "_we"}, {31'd0, we}, {31'd0, vecs[i].ewe});
        chk({vecs[i].name, "_wdata"}, fw, vecs[i].ewdata);
      end
      chk({vecs[i].name, "_valid"}, {31'd0, v}, {31'd0, vecs[i].evalid});
      chk({vecs[i].name, "_err"}, {31'd0, e}, {31'd0, vecs[i].eerr});
      if (vecs[i].chk_load) chk({vecs[i].name, "_load"}, ld, vecs[i].eload);
      @(negedge clk);
      chk({vecs[i].name, "_idle"}, {30'd0, bus_req_o, stall_o}, 32'd0);
    end

    // Flush during REQ: bus still completes, but the load result is dropped.
    run_txn(1, 0, 3'b000, 32'h40, 32'h0, 32'h55AA55AA, 2, 1, st, rq, a, s, fa, fb, we, fw, v, e, ld, dn);
    chk("flush_done", {31'd0, dn}, 32'd1);
    chk("flush_reqs", rq, 2);
    chk("flush_valid", {31'd0, v}, 32'd0);

    // Flush during a timed-out access suppresses the bus error.
    run_txn(1, 0, 3'b000, 32'h44, 32'h0, 32'h0, 0, 3, st, rq, a, s, fa, fb, we, fw, v, e, ld, dn);
    chk("flush_to_reqs", rq, 16);
    chk("flush_to_err", {31'd0, e}, 32'd0);
    chk("flush_to_valid", {31'd0, v}, 32'd0);

    // Flush in IDLE: no access at all.
    @(posedge clk); #1;
    MemRead_mem_i = 1; ALUOut_mem_i = 32'h48; flush_i = 1;
    @(negedge clk);
    chk("flush_idle_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    chk("flush_idle_req", {31'd0, bus_req_o}, 32'd0);
    MemRead_mem_i = 0; flush_i = 0;

    // Stray ack in IDLE is ignored.
    @(posedge clk); #1 bus_ack_i = 1; bus_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("stray_ack_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1 bus_ack_i = 0;
    @(negedge clk);
    chk("stray_ack_valid", {31'd0, load_valid_o}, 32'd0);

    // Reset in the middle of REQ clears the request and stall immediately.
    @(posedge clk); #1;
    MemRead_mem_i = 1; ALUOut_mem_i = 32'h60; BEOp_mem_i = 3'b000;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", {31'd0, bus_req_o}, 32'd1);
    rst = 0; #1;
    chk("async_rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("async_rst_stall", {31'd0, stall_o}, 32'd0);
    MemRead_mem_i = 0;
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("post_rst_idle", {30'd0, bus_req_o, stall_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
